instr_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the datapath. It fetches 32-bit instructions from instruction memory over a req/ack handshake and holds each one stable on the datapath instruction bus for its execute phase. Between instructions it drives NOP, and it gates register-file writes so every instruction writes exactly once. It also runs the data-memory handshake for LOAD/STORE and reports halt, error and retired-instruction count.

---
 rtl/instr_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_instr_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec control FSM
// driving the datapath instruction bus, rf write gate and dmem handshake.
module instr_sequencer #(
  parameter int unsigned         PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         TIMEOUT  = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         instr_out,
  output logic                rf_we_gate,
  output logic                dm_req,
  output logic                dm_wnr,
  input  logic                dm_ack,
  output logic                busy,
  output logic                halted,
  output logic                error,
  output logic [15:0]         retired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TM1 = CW'(TIMEOUT - 1);

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_ADDI  = 6'd2;
  localparam logic [5:0] OP_LOAD  = 6'd3;
  localparam logic [5:0] OP_LOADI = 6'd4;
  localparam logic [5:0] OP_STORE = 6'd5;
  localparam logic [5:0] OP_HALT  = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         ir;
  logic [CW-1:0]       cnt;

  logic       pc_inc;
  logic       ret_inc;
  logic       set_err;
  logic       ld_ir;
  logic       restart;
  logic       tmo;
  logic [5:0] op;
  logic       is_nop;
  logic       is_halt;
  logic       is_alu;
  logic       is_mem;
  logic       is_store;
  logic       in_wait;

  assign op       = ir[31:26];
  assign is_nop   = (op == OP_NOP);
  assign is_halt  = (op == OP_HALT);
  assign is_alu   = (op == OP_ADD) || (op == OP_ADDI)
                 || (op == OP_LOADI);
  assign is_store = (op == OP_STORE);
  assign is_mem   = (op == OP_LOAD) || is_store;
  assign in_wait  = (state == S_FETCH) || (state == S_MEM);
  assign tmo      = (cnt == TM1);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_n = state;
    pc_inc  = 1'b0;
    ret_inc = 1'b0;
    set_err = 1'b0;
    ld_ir   = 1'b0;
    restart = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          restart = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ld_ir   = 1'b1;
          state_n = S_DECODE;
        end else if (tmo) begin
          set_err = 1'b1;
          state_n = S_HALT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_nop: begin
            pc_inc  = 1'b1;
            ret_inc = 1'b1;
            state_n = S_FETCH;
          end
          is_halt: begin
            ret_inc = 1'b1;
            state_n = S_HALT;
          end
          is_alu, is_mem: begin
            state_n = S_EXEC;
          end
          default: begin
            set_err = 1'b1;
            state_n = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        if (is_alu) begin
          pc_inc  = 1'b1;
          ret_inc = 1'b1;
          state_n = S_FETCH;
        end else if (is_mem) begin
          state_n = S_MEM;
        end else begin
          set_err = 1'b1;
          state_n = S_HALT;
        end
      end
      S_MEM: begin
        if (dm_ack) begin
          if (is_store) begin
            pc_inc  = 1'b1;
            ret_inc = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (tmo) begin
          set_err = 1'b1;
          state_n = S_HALT;
        end
      end
      S_WB: begin
        pc_inc  = 1'b1;
        ret_inc = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // PC, IR, error flag and retire counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      error   <= 1'b0;
      retired <= '0;
    end else begin
      if (restart)     pc <= RESET_PC;
      else if (pc_inc) pc <= pc + PC_WIDTH'(1);
      if (ld_ir) ir <= imem_rdata;
      if (restart)      error <= 1'b0;
      else if (set_err) error <= 1'b1;
      if (restart)      retired <= '0;
      else if (ret_inc) retired <= retired + 16'd1;
    end
  end

  // Wait counter restarts whenever a FETCH or MEM wait begins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      cnt <= '0;
    else if (state_n != state)         cnt <= '0;
    else if (in_wait && !tmo)          cnt <= cnt + CW'(1);
  end

  assign imem_req   = (state == S_FETCH);
  assign imem_addr  = pc;
  assign dm_req     = (state == S_MEM);
  assign dm_wnr     = (state == S_MEM) && is_store;
  assign busy       = (state != S_IDLE) && (state != S_HALT);
  assign halted     = (state == S_HALT);
  assign rf_we_gate = ((state == S_EXEC) && is_alu)
                   || (state == S_WB);
  assign instr_out  = ((state == S_EXEC) || (state == S_MEM)
                    || (state == S_WB)) ? ir : 32'h0;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed + randomized programs
// against a program-level reference walk.
module tb_instr_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        rf_we_gate;
  logic        dm_req;
  logic        dm_wnr;
  logic        dm_ack;
  logic        busy;
  logic        halted;
  logic        error;
  logic [15:0] retired;

  instr_sequencer #(
    .PC_WIDTH(8),
    .RESET_PC(8'd0),
    .TIMEOUT(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_out(instr_out),
    .rf_we_gate(rf_we_gate),
    .dm_req(dm_req),
    .dm_wnr(dm_wnr),
    .dm_ack(dm_ack),
    .busy(busy),
    .halted(halted),
    .error(error),
    .retired(retired)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] imem [256];

  // responder controls
  bit imem_en    = 1'b0;
  bit force_iack = 1'b0;
  int imin = 0, imax = 0, dmin = 0, dmax = 0;
  int iw_cnt = 0, iw_tgt = 0, dw_cnt = 0, dw_tgt = 0;

  // monitor records
  logic [7:0]  fetch_q [$];
  logic [31:0] rf_q [$];
  int          rf_cyc_q [$];
  logic        dm_q [$];
  int          mon_cyc = 0;
  int          dm_ack_cyc = -1;
  int          dm_cycles = 0;
  logic [31:0] watch_instr = 32'h0;
  int          watch_cycles = 0;
  bit          st_flag = 1'b0;
  logic [15:0] ret_at_ack = 16'hFFFF;
  logic [15:0] ret_after = 16'hFFFF;

  // reference expectations
  logic [7:0]  exp_fetch [$];
  logic [31:0] exp_rf [$];
  logic        exp_dm [$];
  logic [15:0] exp_ret;
  logic        exp_err;
  logic [7:0]  exp_pc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // memory responders: drive acks just after each rising edge
  initial begin
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    dm_ack = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!imem_en) begin
        imem_ack = force_iack;
        imem_rdata = $urandom;
      end else if (imem_req) begin
        if (iw_cnt >= iw_tgt) begin
          imem_ack = 1'b1;
          imem_rdata = imem[imem_addr];
        end else begin
          imem_ack = 1'b0;
          imem_rdata = $urandom;
          iw_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        iw_cnt = 0;
        iw_tgt = $urandom_range(imax, imin);
      end
      if (dm_req) begin
        if (dw_cnt >= dw_tgt) dm_ack = 1'b1;
        else begin
          dm_ack = 1'b0;
          dw_cnt++;
        end
      end else begin
        dm_ack = 1'b0;
        dw_cnt = 0;
        dw_tgt = $urandom_range(dmax, dmin);
      end
    end
  end

  // observe DUT on falling edges
  initial begin
    forever begin
      @(negedge clock);
      mon_cyc++;
      if (st_flag) begin
        ret_after = retired;
        st_flag = 1'b0;
      end
      if (imem_req && imem_ack) fetch_q.push_back(imem_addr);
      if (rf_we_gate) begin
        rf_q.push_back(instr_out);
        rf_cyc_q.push_back(mon_cyc);
      end
      if (dm_req) dm_cycles++;
      if (dm_req && dm_ack) begin
        dm_q.push_back(dm_wnr);
        dm_ack_cyc = mon_cyc;
        if (dm_wnr) begin
          ret_at_ack = retired;
          st_flag = 1'b1;
        end
      end
      if (watch_instr != 32'h0 && instr_out == watch_instr)
        watch_cycles++;
    end
  end

  task automatic clear_mon();
    fetch_q.delete();
    rf_q.delete();
    rf_cyc_q.delete();
    dm_q.delete();
    dm_cycles = 0;
    dm_ack_cyc = -1;
    watch_cycles = 0;
    st_flag = 1'b0;
    ret_at_ack = 16'hFFFF;
    ret_after = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) imem[a] = {6'd63, 26'($urandom)};
  endtask

  // walk the program instruction by instruction
  task automatic model();
    logic [7:0]  pc;
    logic [31:0] ins;
    logic [5:0]  op;
    pc = 8'd0;
    exp_ret = 16'd0;
    exp_err = 1'b0;
    exp_fetch.delete();
    exp_rf.delete();
    exp_dm.delete();
    for (int step = 0; step < 300; step++) begin
      ins = imem[pc];
      op = ins[31:26];
      exp_fetch.push_back(pc);
      if (op == 6'd63) begin
        exp_ret++;
        break;
      end else if (op == 6'd0) begin
        pc++;
        exp_ret++;
      end else if (op == 6'd1 || op == 6'd2 || op == 6'd4) begin
        exp_rf.push_back(ins);
        pc++;
        exp_ret++;
      end else if (op == 6'd3) begin
        exp_dm.push_back(1'b0);
        exp_rf.push_back(ins);
        pc++;
        exp_ret++;
      end else if (op == 6'd5) begin
        exp_dm.push_back(1'b1);
        pc++;
        exp_ret++;
      end else begin
        exp_err = 1'b1;
        break;
      end
    end
    exp_pc = pc;
  endtask

  task automatic compare_run(input string tag);
    chk({tag, "_nfetch"}, 32'(fetch_q.size()), 32'(exp_fetch.size()));
    for (int i = 0; i < fetch_q.size() && i < exp_fetch.size(); i++)
      chk({tag, "_faddr"}, 32'(fetch_q[i]), 32'(exp_fetch[i]));
    chk({tag, "_nrf"}, 32'(rf_q.size()), 32'(exp_rf.size()));
    for (int i = 0; i < rf_q.size() && i < exp_rf.size(); i++)
      chk({tag, "_rfinstr"}, rf_q[i], exp_rf[i]);
    chk({tag, "_ndm"}, 32'(dm_q.size()), 32'(exp_dm.size()));
    for (int i = 0; i < dm_q.size() && i < exp_dm.size(); i++)
      chk({tag, "_wnr"}, 32'(dm_q[i]), 32'(exp_dm[i]));
    chk({tag, "_retired"}, 32'(retired), 32'(exp_ret));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_pc"}, 32'(imem_addr), 32'(exp_pc));
    chk({tag, "_instr0"}, instr_out, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int cyc;
  int len;
  int r;
  logic [5:0] rop;
  logic [31:0] ld_ins;

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    fill_halt();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_rfwe", 32'(rf_we_gate), 32'd0);
    chk("rst_dm", 32'({dm_req, dm_wnr}), 32'd0);

    // async reset in the middle of a stalled fetch
    pulse_start();
    repeat (2) @(negedge clock);
    chk("midfetch_req", 32'(imem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(imem_req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rerst_addr", 32'(imem_addr), 32'd0);
    chk("rerst_idle", 32'({busy, halted, error}), 32'd0);

    // ADD, LOADI, HALT with zero-wait fetches
    imem_en = 1'b1;
    imin = 0; imax = 0; dmin = 0; dmax = 0;
    fill_halt();
    imem[0] = {6'd1, 26'h0123456};
    imem[1] = {6'd4, 26'h0ABCDEF};
    imem[2] = {6'd63, 26'h0};
    model();
    @(negedge clock);
    clear_mon();
    pulse_start();
    run_to_halt(200, cyc);
    chk("alu_cycles", 32'(cyc), 32'd8);
    chk("alu_halted", 32'(halted), 32'd1);
    compare_run("alu");

    // LOAD with dmem ack delayed three cycles
    fill_halt();
    ld_ins = {6'd3, 26'h1555555};
    imem[0] = ld_ins;
    model();
    dmin = 3; dmax = 3;
    clear_mon();
    watch_instr = ld_ins;
    pulse_start();
    run_to_halt(200, cyc);
    chk("ld_dm_cycles", 32'(dm_cycles), 32'd4);
    chk("ld_ir_cycles", 32'(watch_cycles), 32'd6);
    chk("ld_rf_in_wb", 32'(rf_cyc_q.size() > 0 ? rf_cyc_q[0] : -9),
        32'(dm_ack_cyc + 1));
    compare_run("load");
    watch_instr = 32'h0;

    // STORE: write access, no rf write, retire on ack
    fill_halt();
    imem[0] = {6'd5, 26'h2AAAAAA};
    model();
    dmin = 0; dmax = 2;
    clear_mon();
    pulse_start();
    run_to_halt(200, cyc);
    chk("st_ret_at_ack", 32'(ret_at_ack), 32'd0);
    chk("st_ret_after", 32'(ret_after), 32'd1);
    compare_run("store");

    // illegal opcode then restart
    fill_halt();
    imem[0] = {6'd7, 26'h0};
    model();
    clear_mon();
    pulse_start();
    run_to_halt(200, cyc);
    chk("ill_halted", 32'(halted), 32'd1);
    compare_run("illegal");
    clear_mon();
    pulse_start();
    chk("ill_err_clr", 32'(error), 32'd0);
    chk("ill_refetch", 32'(imem_addr), 32'd0);
    chk("ill_req", 32'(imem_req), 32'd1);
    run_to_halt(200, cyc);
    compare_run("illegal2");

    // fetch timeout with a late ack afterwards
    imem_en = 1'b0;
    force_iack = 1'b0;
    clear_mon();
    pulse_start();
    cyc = 0;
    while (imem_req && cyc < 100) begin
      cyc++;
      @(negedge clock);
    end
    chk("tmo_req_cycles", 32'(cyc), 32'd16);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_halted", 32'(halted), 32'd1);
    force_iack = 1'b1;
    repeat (3) @(negedge clock);
    force_iack = 1'b0;
    @(negedge clock);
    chk("late_halted", 32'(halted), 32'd1);
    chk("late_req", 32'(imem_req), 32'd0);
    chk("late_retired", 32'(retired), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    imem_en = 1'b1;

    // random programs with random wait states
    imin = 0; imax = 3; dmin = 0; dmax = 3;
    for (int t = 0; t < 10; t++) begin
      fill_halt();
      len = $urandom_range(12, 3);
      for (int i = 0; i < len - 1; i++) begin
        r = $urandom_range(19, 0);
        if (r < 18) rop = 6'(r % 6);
        else rop = 6'($urandom_range(62, 6));
        imem[i] = {rop, 26'($urandom)};
      end
      model();
      clear_mon();
      pulse_start();
      run_to_halt(3000, cyc);
      compare_run("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
